// File: rtl/llc_line_responder.sv
// Memory-side responder for the last-level-cache line interface.
// Writes are absorbed into an on-chip line array; reads return a whole line after LATENCY cycles.
module llc_line_responder #(
    parameter int unsigned B          = 64,
    parameter int unsigned PADDR_BITS = 64,
    parameter int unsigned LINES      = 256,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  lc_valid_in,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [8*B-1:0]        lc_value_in,
    input  logic                  lc_we_in,
    output logic                  lc_ready_out,
    output logic                  lc_valid_out,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [8*B-1:0]        lc_value_out,
    input  logic                  lc_ready_in
);

    localparam int unsigned OffW  = $clog2(B);
    localparam int unsigned IdxW  = $clog2(LINES);
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned DataW = 8 * B;
    localparam logic [PADDR_BITS-1:0] OffMask = PADDR_BITS'(B - 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [PADDR_BITS-1:0] addr_q, addr_d;
    logic [DataW-1:0]      value_q, value_d;
    logic                  valid_q, valid_d;

    logic [DataW-1:0]      mem_q [LINES];

    logic                  req_fire;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [IdxW-1:0]       req_idx;

    // Gated by reset so the initiator sees not-ready while reset is held.
    assign lc_ready_out = rst_N_in && (state_q == StIdle);
    assign req_fire     = lc_valid_in && lc_ready_out;
    assign rd_fire      = req_fire && !lc_we_in;
    assign wr_fire      = req_fire && lc_we_in;
    assign req_idx      = lc_addr_in[OffW +: IdxW];

    assign lc_valid_out = valid_q;
    assign lc_addr_out  = addr_q;
    assign lc_value_out = value_q;

    // Backing array is deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (wr_fire) begin
            mem_q[req_idx] <= lc_value_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        value_d = value_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (rd_fire) begin
                    idx_d   = req_idx;
                    addr_d  = lc_addr_in & ~OffMask;
                    cnt_d   = CntLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Counter runs LATENCY-1 .. 0, so valid rises after edge T+LATENCY.
                if (cnt_q == '0) begin
                    value_d = mem_q[idx_q];
                    valid_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (lc_ready_in) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_llc_line_responder.sv
// Directed bench for llc_line_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_llc_line_responder;

    localparam int unsigned DW = 512;
    localparam logic [DW-1:0] LA   = {8{64'hDEADBEEF_CAFEF00D}};
    localparam logic [DW-1:0] LP2  = {8{64'h0123_4567_89AB_CDEF}};
    localparam logic [DW-1:0] LJNK = {16{32'hBAD0_BAD0}};
    localparam logic [DW-1:0] LAA  = {16{32'hAAAA_5555}};
    localparam logic [DW-1:0] LBB  = {16{32'h1234_BBBB}};
    localparam logic [DW-1:0] LC   = {8{64'hC0C0_1111_2222_3333}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          v_in, we, rdy_in, rdy_out, v_out;
    logic [63:0]   addr_in, addr_out;
    logic [DW-1:0] val_in, val_out;
    logic          s_v_in, s_we, s_rdy_in, s_rdy_out, s_v_out;
    logic [63:0]   s_addr_in, s_addr_out;
    logic [DW-1:0] s_val_in, s_val_out;

    int total = 0;
    int bad   = 0;

    llc_line_responder #(.B(64), .PADDR_BITS(64), .LINES(256), .LATENCY(4)) u_dut4 (
        .clk_in      (clk),
        .rst_N_in    (rst_n),
        .lc_valid_in (v_in),
        .lc_addr_in  (addr_in),
        .lc_value_in (val_in),
        .lc_we_in    (we),
        .lc_ready_out(rdy_out),
        .lc_valid_out(v_out),
        .lc_addr_out (addr_out),
        .lc_value_out(val_out),
        .lc_ready_in (rdy_in)
    );

    llc_line_responder #(.B(64), .PADDR_BITS(64), .LINES(256), .LATENCY(1)) u_dut1 (
        .clk_in      (clk),
        .rst_N_in    (rst_n),
        .lc_valid_in (s_v_in),
        .lc_addr_in  (s_addr_in),
        .lc_value_in (s_val_in),
        .lc_we_in    (s_we),
        .lc_ready_out(s_rdy_out),
        .lc_valid_out(s_v_out),
        .lc_addr_out (s_addr_out),
        .lc_value_out(s_val_out),
        .lc_ready_in (s_rdy_in)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v_in = 1'b0; we = 1'b0; rdy_in = 1'b0; addr_in = '0; val_in = '0;
        s_v_in = 1'b0; s_we = 1'b0; s_rdy_in = 1'b1; s_addr_in = '0; s_val_in = '0;

        // Reset / idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", rdy_out, '0);
            chk("rst_valid", v_out, '0);
        end
        chk("rst_addr", addr_out, '0);
        chk("rst_value", val_out, '0);
        chk("rst_valid_l1", s_v_out, '0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", rdy_out, 1);
        chk("post_rst_valid", v_out, '0);

        // Write then read, LATENCY=4
        v_in = 1'b1; we = 1'b1; addr_in = 64'h1040; val_in = LA;
        step();
        we = 1'b0; addr_in = 64'h107F;
        chk("wr_ready_again", rdy_out, 1);
        step();
        v_in = 1'b0;
        chk("rd_busy_t0", rdy_out, '0);
        chk("rd_valid_t0", v_out, '0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("rd_valid_early", v_out, '0);
            chk("rd_busy", rdy_out, '0);
        end
        step();
        chk("rd_valid_t4", v_out, 1);
        chk("rd_addr", addr_out, 64'h1040);
        chk("rd_value", val_out, LA);
        chk("rd_busy_resp", rdy_out, '0);
        rdy_in = 1'b1;
        step();
        chk("rd_valid_drop", v_out, '0);
        chk("rd_ready_back", rdy_out, 1);
        rdy_in = 1'b0;

        // Backpressure, with a write held on the bus while not ready
        v_in = 1'b1; we = 1'b1; addr_in = 64'h2000; val_in = LP2;
        step();
        we = 1'b0;
        step();
        we = 1'b1; val_in = LJNK;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", v_out, 1);
            chk("bp_addr", addr_out, 64'h2000);
            chk("bp_value", val_out, LP2);
            chk("bp_busy", rdy_out, '0);
            step();
        end
        chk("bp_valid_held", v_out, 1);
        rdy_in = 1'b1;
        step();
        v_in = 1'b0; rdy_in = 1'b0;
        chk("bp_valid_drop", v_out, '0);
        chk("bp_ready_back", rdy_out, 1);

        // Aliasing, back-to-back writes
        v_in = 1'b1; we = 1'b1; addr_in = 64'h0000; val_in = LAA;
        step();
        chk("alias_wr1_nostall", rdy_out, 1);
        addr_in = 64'h4000; val_in = LBB;
        step();
        chk("alias_wr2_nostall", rdy_out, 1);
        we = 1'b0; addr_in = 64'h0000; rdy_in = 1'b1;
        step();
        v_in = 1'b0;
        repeat (3) step();
        chk("alias_valid_early", v_out, '0);
        step();
        chk("alias_valid", v_out, 1);
        chk("alias_value", val_out, LBB);
        chk("alias_addr", addr_out, 64'h0000);
        step();
        chk("alias_pulse_end", v_out, '0);
        chk("alias_ready", rdy_out, 1);
        rdy_in = 1'b0;

        // LATENCY=1 build, lc_ready_in tied high
        s_v_in = 1'b1; s_we = 1'b1; s_addr_in = 64'h80; s_val_in = LC;
        step();
        s_we = 1'b0; s_addr_in = 64'h9F;
        step();
        chk("l1_valid_t0", s_v_out, '0);
        chk("l1_busy_t0", s_rdy_out, '0);
        step();
        chk("l1_valid_t1", s_v_out, 1);
        chk("l1_value", s_val_out, LC);
        chk("l1_addr", s_addr_out, 64'h80);
        step();
        chk("l1_pulse_end", s_v_out, '0);
        chk("l1_ready_t2", s_rdy_out, 1);
        step();
        chk("l1_next_accepted", s_rdy_out, '0);
        s_v_in = 1'b0;
        step();
        chk("l1_next_valid", s_v_out, 1);
        step();
        chk("l1_next_end", s_v_out, '0);

        // Reset mid-read
        v_in = 1'b1; we = 1'b0; addr_in = 64'h2000;
        step();
        v_in = 1'b0;
        step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", v_out, '0);
        chk("mrst_ready", rdy_out, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mrst_no_stale", v_out, '0);
        end
        chk("mrst_ready_back", rdy_out, 1);
        v_in = 1'b1; we = 1'b0; addr_in = 64'h2000; rdy_in = 1'b1;
        step();
        v_in = 1'b0;
        repeat (3) step();
        step();
        chk("mrst_reread_valid", v_out, 1);
        chk("mrst_reread_value", val_out, LP2);
        chk("mrst_reread_addr", addr_out, 64'h2000);
        step();
        rdy_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
